// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - shares one memory port between I/D block fills and D write-through
// Optional feature: define MEM_FILL_ARB_RR_EN for round-robin I/D miss tie-break.
module mem_fill_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss_req,
  input  logic [ADDR_WIDTH-1:0]          i_miss_addr,
  input  logic                           d_miss_req,
  input  logic [ADDR_WIDTH-1:0]          d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_WIDTH-1:0]          d_wr_addr,
  input  logic [15:0]                    d_wr_data,
  output logic                           d_wr_ack,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid,
  output logic                           busy
);

  localparam int WW  = $clog2(BLOCK_WORDS);
  localparam int OFF = WW + 1;
  localparam int CW  = WW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0]         LAST_IDX = CW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

  if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_block
    $error("BLOCK_WORDS must be a power of 2 and at least 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end

  logic [1:0]            state_q, state_d, st;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]         recv_cnt_q, recv_cnt_d;
  logic                  pick;
`ifdef MEM_FILL_ARB_RR_EN
  logic                  last_grant_q, last_grant_d;
`endif

  // owner/pick encoding: 0 = I-cache, 1 = D-cache
`ifdef MEM_FILL_ARB_RR_EN
  assign pick = (i_miss_req && d_miss_req) ? ~last_grant_q : d_miss_req;
`else
  assign pick = d_miss_req;
`endif

  // During reset the outputs decode as IDLE so a write can still go through.
  assign st = rst ? S_IDLE : state_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
`ifdef MEM_FILL_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    d_wr_ack    = 1'b0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    fill_data   = '0;
    fill_word   = '0;
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_data_in = '0;
    busy        = (st != S_IDLE);

    case (st)
      S_IDLE: begin
        if (d_wr_req) begin
          d_wr_ack    = 1'b1;
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = d_wr_addr;
          mem_data_in = d_wr_data;
        end else if (!rst && (i_miss_req || d_miss_req)) begin
          owner_d     = pick;
          base_d      = (pick ? d_miss_addr : i_miss_addr) & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = S_ISSUE;
`ifdef MEM_FILL_ARB_RR_EN
          last_grant_d = pick;
`endif
        end
      end
      S_ISSUE: begin
        mem_enable  = 1'b1;
        mem_addr    = base_q + ADDR_WIDTH'({issue_cnt_q, 1'b0});
        issue_cnt_d = issue_cnt_q + CW'(1);
        if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DONE: begin
        i_fill_done = ~owner_q;
        d_fill_done = owner_q;
        state_d     = S_IDLE;
      end
      default: ;
    endcase

    // Returns overlap issue; the last word wins over the ISSUE->DRAIN step.
    if ((st == S_ISSUE || st == S_DRAIN) && mem_data_valid) begin
      i_fill_we  = ~owner_q;
      d_fill_we  = owner_q;
      fill_data  = mem_data_out;
      fill_word  = recv_cnt_q[WW-1:0];
      recv_cnt_d = recv_cnt_q + CW'(1);
      if (recv_cnt_q == LAST_IDX) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef MEM_FILL_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef MEM_FILL_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - self-checking bench for mem_fill_arbiter
// Honours MEM_FILL_ARB_RR_EN when defined.
module tb_mem_fill_arbiter;
  localparam int AW  = 16;
  localparam int BW  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_miss_req = 1'b0;
  logic [AW-1:0] i_miss_addr = '0;
  logic d_miss_req = 1'b0;
  logic [AW-1:0] d_miss_addr = '0;
  logic d_wr_req = 1'b0;
  logic [AW-1:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic d_wr_ack, i_fill_we, d_fill_we, i_fill_done, d_fill_done;
  logic [15:0] fill_data;
  logic [2:0] fill_word;
  logic [AW-1:0] mem_addr;
  logic mem_enable, mem_wr;
  logic [15:0] mem_data_in, mem_data_out;
  logic mem_data_valid;
  logic busy;

  mem_fill_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .fill_data(fill_data), .fill_word(fill_word),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Memory with fixed read latency; its pipeline clears on rst.
  logic [15:0] mem [0:32767];
  logic mem_init = 1'b0;
  logic pl_en = 1'b0;
  logic [14:0] pl_a = '0;
  logic [15:0] pl_d = '0;
  logic pv [1:LAT];
  logic [15:0] pd [1:LAT];
  logic [15:0] junk;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'((i * 40503) ^ 23130);
      mem_init <= 1'b1;
    end else begin
      if (pl_en) mem[pl_a] <= pl_d;
      if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_data_in;
    end
    junk <= 16'($urandom);
    if (rst) begin
      for (int k = 1; k <= LAT; k++) pv[k] <= 1'b0;
    end else begin
      pv[1] <= mem_enable && !mem_wr;
      pd[1] <= mem[mem_addr[15:1]];
      for (int k = 2; k <= LAT; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end
  assign mem_data_valid = pv[LAT];
  assign mem_data_out   = pv[LAT] ? pd[LAT] : junk;

  // Reference model: m_ph counts cycles since the grant (0 = idle).
  int   m_ph = 0, nx_ph = 0;
  int   m_base = 0, nx_base = 0;
  logic m_owner = 1'b0, nx_owner = 1'b0;
  logic m_last = 1'b0, nx_last = 1'b0;
  logic exp_ack, exp_iwe, exp_dwe, exp_idone, exp_ddone, exp_en, exp_wr, exp_busy;
  logic [15:0] exp_data, exp_addr, exp_din;
  logic [2:0] exp_word;

  always @(negedge clk) begin : model
    int w;
    logic pk;
    exp_ack = 0; exp_iwe = 0; exp_dwe = 0; exp_idone = 0; exp_ddone = 0;
    exp_en = 0; exp_wr = 0; exp_busy = 0;
    exp_data = '0; exp_addr = '0; exp_din = '0; exp_word = '0;
    nx_ph = m_ph; nx_base = m_base; nx_owner = m_owner; nx_last = m_last;
    if (rst || m_ph == 0) begin
      if (d_wr_req) begin
        exp_ack = 1; exp_en = 1; exp_wr = 1; exp_addr = d_wr_addr; exp_din = d_wr_data;
      end else if (!rst && (i_miss_req || d_miss_req)) begin
`ifdef MEM_FILL_ARB_RR_EN
        pk = (i_miss_req && d_miss_req) ? !m_last : d_miss_req;
`else
        pk = d_miss_req;
`endif
        nx_owner = pk;
        nx_last  = pk;
        nx_base  = int'(pk ? d_miss_addr : i_miss_addr) & ~(2 * BW - 1);
        nx_ph    = 1;
      end
      if (rst) begin
        nx_ph = 0;
        nx_last = 0;
      end
    end else begin
      exp_busy = 1;
      if (m_ph <= BW) begin
        exp_en = 1;
        exp_addr = 16'(m_base + 2 * (m_ph - 1));
      end
      if (m_ph > LAT && m_ph <= BW + LAT) begin
        w = m_ph - LAT - 1;
        exp_iwe = !m_owner; exp_dwe = m_owner;
        exp_word = 3'(w);
        exp_data = mem[15'((m_base >> 1) + w)];
      end
      if (m_ph == BW + LAT + 1) begin
        exp_idone = !m_owner; exp_ddone = m_owner;
        nx_ph = 0;
      end else begin
        nx_ph = m_ph + 1;
      end
    end
    if (cyc >= 1) begin
      chk("d_wr_ack", d_wr_ack, exp_ack);
      chk("i_fill_we", i_fill_we, exp_iwe);
      chk("d_fill_we", d_fill_we, exp_dwe);
      chk("i_fill_done", i_fill_done, exp_idone);
      chk("d_fill_done", d_fill_done, exp_ddone);
      chk("fill_data", fill_data, exp_data);
      chk("fill_word", fill_word, exp_word);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_enable", mem_enable, exp_en);
      chk("mem_wr", mem_wr, exp_wr);
      chk("mem_data_in", mem_data_in, exp_din);
      chk("busy", busy, exp_busy);
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_ph    <= nx_ph;
    m_base  <= nx_base;
    m_owner <= nx_owner;
    m_last  <= nx_last;
  end

  task automatic preload(input logic [15:0] byte_addr, input logic [15:0] data);
    pl_en = 1'b1; pl_a = byte_addr[15:1]; pl_d = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(7) == 0) return 16'hFF00 | 16'($urandom_range(255));
    return 16'($urandom);
  endfunction

  initial begin
    int d_at, i_at, cnt;
    logic seen;

    repeat (2) @(posedge clk); #1;
    d_wr_req = 1; d_wr_addr = 16'h0010; d_wr_data = 16'h1111;
    @(negedge clk);
    chk("rst_wr_ack", d_wr_ack, 1);
    chk("rst_wr_mem_wr", mem_wr, 1);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    d_wr_req = 0; rst = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_mem_enable", mem_enable, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_fill_word", fill_word, 0);
    @(posedge clk); #1;

    // Simultaneous misses straight after reset: D wins in both modes.
    i_miss_req = 1; i_miss_addr = 16'h0100; d_miss_req = 1; d_miss_addr = 16'h0200;
    d_at = -1; i_at = -1;
    for (int k = 0; k <= 29; k++) begin
      @(negedge clk);
      if (d_fill_done) d_at = k;
      if (i_fill_done) i_at = k;
      if (k == 15) chk("tie1_i_first_addr", mem_addr, 16'h0100);
      @(posedge clk); #1;
      if (k == 13) d_miss_req = 0;
      if (k == 27) i_miss_req = 0;
    end
    chk("tie1_d_done_cycle", d_at, 13);
    chk("tie1_i_done_cycle", i_at, 27);

    // Lone D miss, then a tie.
    d_miss_req = 1; d_miss_addr = 16'h0300;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 13) d_miss_req = 0;
    end
    i_miss_req = 1; i_miss_addr = 16'h0400; d_miss_req = 1; d_miss_addr = 16'h0500;
    for (int k = 0; k <= 29; k++) begin
      @(negedge clk);
`ifdef MEM_FILL_ARB_RR_EN
      if (k == 1) chk("tie2_winner_addr", mem_addr, 16'h0400);
`else
      if (k == 1) chk("tie2_winner_addr", mem_addr, 16'h0500);
`endif
      @(posedge clk); #1;
`ifdef MEM_FILL_ARB_RR_EN
      if (k == 13) i_miss_req = 0;
      if (k == 27) d_miss_req = 0;
`else
      if (k == 13) d_miss_req = 0;
      if (k == 27) i_miss_req = 0;
`endif
    end

    // I miss without contention.
    for (int j = 0; j < 8; j++) preload(16'h1230 + 16'(2 * j), 16'hA000 + 16'(j));
    i_miss_req = 1; i_miss_addr = 16'h1234;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 0) chk("imiss_c0_busy", busy, 0);
      if (k == 1) chk("imiss_c1_addr", mem_addr, 16'h1230);
      if (k == 8) chk("imiss_c8_addr", mem_addr, 16'h123E);
      if (k == 9) chk("imiss_c9_en", mem_enable, 0);
      if (k == 4) chk("imiss_c4_we", i_fill_we, 0);
      if (k == 5) begin
        chk("imiss_c5_we", i_fill_we, 1);
        chk("imiss_c5_word", fill_word, 0);
        chk("imiss_c5_data", fill_data, 16'hA000);
      end
      if (k == 12) begin
        chk("imiss_c12_word", fill_word, 7);
        chk("imiss_c12_data", fill_data, 16'hA007);
      end
      if (k == 13) chk("imiss_c13_done", i_fill_done, 1);
      if (k == 14) chk("imiss_c14_busy", busy, 0);
      @(posedge clk); #1;
      if (k == 13) i_miss_req = 0;
    end

    // Write arriving during a fill waits for IDLE.
    i_miss_req = 1; i_miss_addr = 16'h2000; seen = 0;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 13 && d_wr_ack) seen = 1;
      if (k == 14) begin
        chk("wfill_ack", d_wr_ack, 1);
        chk("wfill_mem_wr", mem_wr, 1);
        chk("wfill_addr", mem_addr, 16'h0040);
      end
      if (k == 15) chk("wfill_ack_once", d_wr_ack, 0);
      @(posedge clk); #1;
      if (k == 2) begin d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; end
      if (k == 13) i_miss_req = 0;
      if (k == 14) d_wr_req = 0;
    end
    chk("wfill_no_early_ack", seen, 0);
    d_miss_req = 1; d_miss_addr = 16'h0040;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("wback_we", d_fill_we, 1);
        chk("wback_word", fill_word, 0);
        chk("wback_data", fill_data, 16'hBEEF);
      end
      @(posedge clk); #1;
      if (k == 13) d_miss_req = 0;
    end

    // Write and miss in the same IDLE cycle.
    d_wr_req = 1; d_wr_addr = 16'h0300; d_wr_data = 16'h1357;
    d_miss_req = 1; d_miss_addr = 16'h0500;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k == 0) chk("wm_c0_ack", d_wr_ack, 1);
      if (k == 1) begin
        chk("wm_c1_busy", busy, 0);
        chk("wm_c1_en", mem_enable, 0);
      end
      if (k == 2) begin
        chk("wm_c2_en", mem_enable, 1);
        chk("wm_c2_wr", mem_wr, 0);
        chk("wm_c2_addr", mem_addr, 16'h0500);
      end
      if (k == 14) chk("wm_c14_done", d_fill_done, 1);
      @(posedge clk); #1;
      if (k == 0) d_wr_req = 0;
      if (k == 14) d_miss_req = 0;
    end

    // Reset in cycle 6 of a D fill.
    d_miss_req = 1; d_miss_addr = 16'h0600; cnt = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 7) begin
        chk("rmid_busy", busy, 0);
        chk("rmid_en", mem_enable, 0);
        chk("rmid_addr", mem_addr, 0);
        chk("rmid_we", d_fill_we, 0);
        chk("rmid_data", fill_data, 0);
      end
      if (k >= 6 && d_fill_done) cnt++;
      @(posedge clk); #1;
      if (k == 5) begin rst = 1; d_miss_req = 0; end
      if (k == 6) rst = 0;
    end
    chk("rmid_no_done", cnt, 0);
    i_miss_req = 1; i_miss_addr = 16'h0700; i_at = -1;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (i_fill_done) i_at = k;
      @(posedge clk); #1;
      if (k == 13) i_miss_req = 0;
    end
    chk("rmid_after_done_cycle", i_at, 13);

    // Top block: no address wrap.
    preload(16'hFFFE, 16'h7E57);
    d_miss_req = 1; d_miss_addr = 16'hFFFE;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) chk("top_c1_addr", mem_addr, 16'hFFF0);
      if (k == 8) chk("top_c8_addr", mem_addr, 16'hFFFE);
      if (k == 12) begin
        chk("top_c12_word", fill_word, 7);
        chk("top_c12_data", fill_data, 16'h7E57);
      end
      @(posedge clk); #1;
      if (k == 13) d_miss_req = 0;
    end

    // Randomised traffic obeying the requester protocol.
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      if (i_miss_req) begin
        if (exp_idone) i_miss_req = 0;
      end else if ($urandom_range(3) == 0) begin
        i_miss_req = 1; i_miss_addr = rand_addr();
      end
      if (d_miss_req) begin
        if (exp_ddone) d_miss_req = 0;
      end else if ($urandom_range(3) == 0) begin
        d_miss_req = 1; d_miss_addr = rand_addr();
      end
      if (d_wr_req) begin
        if (exp_ack) d_wr_req = 0;
      end else if ($urandom_range(5) == 0) begin
        d_wr_req = 1; d_wr_addr = rand_addr() & 16'hFFFE; d_wr_data = 16'($urandom);
      end
    end
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      if (i_miss_req && exp_idone) i_miss_req = 0;
      if (d_miss_req && exp_ddone) d_miss_req = 0;
      if (d_wr_req && exp_ack) d_wr_req = 0;
    end
    @(negedge clk);
    chk("drain_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Sequencer and arbiter that shares the single multi-cycle memory port (single-cycle write, pipelined fixed-latency read with `data_valid`) between the I-cache miss handler, the D-cache miss handler and the D-cache write-through path. Misses fetch a full cache block as a burst of back-to-back word reads, and the block streams returned words to the owning cache with a word index. Single-word writes use the port only while no fill is in progress. The block sits between both caches and the memory.

## Interface
- `ADDR_WIDTH`, 16: byte address width.
- `BLOCK_WORDS`, 8: 16-bit words per block, power of 2. `OFF = log2(BLOCK_WORDS)+1` is the number of byte-offset bits.
- `MEM_LATENCY`, 4: cycles from read issue to `mem_data_valid`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_miss_req`  in  1  I-cache miss pending; held high until `i_fill_done`.
- `i_miss_addr`  in  ADDR_WIDTH  I-cache miss address; any byte in the block.
- `d_miss_req`, `d_miss_addr`  in  1 / ADDR_WIDTH  D-cache equivalents.
- `d_wr_req`  in  1  write-through request.
- `d_wr_addr`  in  ADDR_WIDTH  write byte address; bit 0 is 0.
- `d_wr_data`  in  16  write data.
- `d_wr_ack`  out  1  write performed this cycle.
- `i_fill_we`, `d_fill_we`  out  1  the word on `fill_data` is valid for that cache.
- `i_fill_done`, `d_fill_done`  out  1  one-cycle pulse when the block is complete.
- `fill_data`  out  16  returned word.
- `fill_word`  out  log2(BLOCK_WORDS)  index of the returned word within the block.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_enable`, `mem_wr`  out  1  memory enable and write select.
- `mem_data_in`  out  16  memory write data.
- `mem_data_out`  in  16  memory read data.
- `mem_data_valid`  in  1  memory read data valid.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE. Registers are `owner` (I/D), `base`, `issue_cnt`, `recv_cnt`, and `last_grant` (only when RR is enabled).
- **IDLE: priorities.** Write beats D miss, and D miss beats I miss. Priority between the two misses changes under Configuration.
- **IDLE: write.** If `d_wr_req` is high, the block drives `mem_enable=1`, `mem_wr=1`, `mem_addr=d_wr_addr` and `mem_data_in=d_wr_data` combinationally. `d_wr_ack=1` in the same cycle, and the state stays IDLE.
- **IDLE: miss grant.** With no write pending and a miss pending, the block latches `owner`. It sets `base = {miss_addr[AW-1:OFF], OFF'b0}`, clears both counters and moves to ISSUE.
- **ISSUE.** The block drives `mem_enable=1`, `mem_wr=0` and `mem_addr = base + 2*issue_cnt`, and increments `issue_cnt`. After BLOCK_WORDS cycles it moves to DRAIN.
- **ISSUE/DRAIN: data return.** Each cycle with `mem_data_valid=1`, the owner's `fill_we=1`, `fill_data=mem_data_out` and `fill_word=recv_cnt`, and `recv_cnt` increments.
- **ISSUE/DRAIN: block complete.** When the last word is received, the state moves to DONE.
- **DONE.** The owner's `fill_done` pulses and the state returns to IDLE. The requester must have `miss_req` low in the following cycle.
- **Ignored inputs.** `mem_data_valid` is ignored in IDLE and DONE. `d_wr_req` waits with `d_wr_ack=0` until IDLE.
- **Address arithmetic.** Addresses stay inside the block, so the top block issues 0xFFF0–0xFFFE with no wrap. Counter widths are log2(BLOCK_WORDS)+1.
- **Unused outputs.** Memory outputs and `fill_data` are 0 when not in use. `fill_word` is 0 outside fills.

## Timing
- **Reset.** On `rst`, the state goes to IDLE, the counters clear and `owner=I`. Every output reads 0 (`busy=0`, `mem_enable=0`, `mem_addr=0`), except that a write is performed and `d_wr_ack` asserted combinationally if `d_wr_req` is high during the reset cycle. With RR enabled, `last_grant=I`.
- **Reset mid-fill.** The fill is abandoned and no `fill_done` is issued. The memory resets its pipeline on the same `rst`, so no stale valids arrive.
- **Miss latency.** Let cycle 0 be the IDLE cycle in which the grant is taken:
  - Reads issue in cycles 1..BLOCK_WORDS.
  - Words return in cycles 1+MEM_LATENCY .. BLOCK_WORDS+MEM_LATENCY.
  - DONE is cycle BLOCK_WORDS+MEM_LATENCY+1, which is 13 at the defaults.
  - The next grant is possible at cycle 14.
- **Write latency.** A write is acked in its request cycle when the state is IDLE. It is 1 memory cycle.
- **Write and miss in the same IDLE cycle.** The write goes first and the miss is granted in the next IDLE cycle.

## Configuration
- `MEM_FILL_ARB_RR_EN`
  - **Defined:** I and D misses tie-break round-robin; the miss not matching `last_grant` wins. `last_grant` updates on each miss grant and resets to I, so the first tie goes to D. Writes keep absolute priority.
  - **Undefined:** D miss always beats I miss, and `last_grant` is absent.

## Test plan
- **I miss, no contention.** `i_miss_addr=0x1234` with memory preloaded:
  - `mem_addr` is 0x1230..0x123E in cycles 1–8.
  - `i_fill_we` is high in cycles 5–12 with `fill_word` 0..7 and data matching memory.
  - `i_fill_done` pulses in cycle 13 and `busy` falls in cycle 14.
- **Simultaneous misses, RR off.** I and D misses in the same cycle: the D fill completes first, and the I grant comes in the IDLE cycle after `d_fill_done`. With `MEM_FILL_ARB_RR_EN`, a second simultaneous tie goes to I.
- **Write during a fill.** `d_wr_req` to 0x0040 with 0xBEEF, asserted in cycle 3 of an I fill: `d_wr_ack` stays 0 until the first IDLE cycle, then asserts for exactly one cycle with `mem_wr=1`. A later D miss to 0x0040 returns 0xBEEF at word 0.
- **Write and miss together in IDLE.** The write is acked in cycle 0, the miss is granted in cycle 1, and its first read issues in cycle 2.
- **Reset mid-fill.** `rst` in cycle 6 of a D fill: all outputs are 0 after the reset edge and no `d_fill_done` is issued. A new I miss afterwards completes with normal 13-cycle timing.
- **Top block.** `d_miss_addr=0xFFFE` issues 0xFFF0..0xFFFE with no address wrap, and `fill_word` 7 carries mem[0xFFFE].
